// File: rtl/inst_mem_sync_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_sync_pkg
// Shared constants for the synchronous instruction memory and its response
// buffer: default bus widths, default memory depth, response buffer depth and
// the all-zero instruction word returned for errored or idle responses.
// -----------------------------------------------------------------------------
package inst_mem_sync_pkg;

   localparam int INST_W              = 32;
   localparam int INST_ADDR_W         = 32;
   localparam int INST_MEM_DEPTH_LOG2 = 12;
   localparam int INST_RSP_FIFO_DEPTH = 2;

   localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

endpackage : inst_mem_sync_pkg

// File: rtl/inst_rsp_fifo.sv
// -----------------------------------------------------------------------------
// inst_rsp_fifo
// Two-entry fall-through response buffer. Entry 0 is always the head and is
// visible on head_*_o as soon as it is written. Push and pop may happen in the
// same cycle; flush empties the buffer and wins over push/pop.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i           drop all buffered entries
//   push_i            write push_data_i/push_err_i behind the current tail
//   pop_i             remove the head entry (ignored when empty)
//   push_data_i       instruction word to store
//   push_err_i        error flag to store with the word
//   cnt_o             number of valid entries (0..2)
//   head_data_o       head instruction word
//   head_err_o        head error flag
// -----------------------------------------------------------------------------
module inst_rsp_fifo
   import inst_mem_sync_pkg::*;
#(
   parameter int DATA_W = INST_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              push_err_i,
   output logic [1:0]        cnt_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic              head_err_o
);

   logic [DATA_W-1:0]              data_q [INST_RSP_FIFO_DEPTH];
   logic [DATA_W-1:0]              data_d [INST_RSP_FIFO_DEPTH];
   logic [INST_RSP_FIFO_DEPTH-1:0] err_q;
   logic [INST_RSP_FIFO_DEPTH-1:0] err_d;
   logic [1:0]                     cnt_q;
   logic [1:0]                     cnt_d;
   logic [1:0]                     wr_slot;
   logic                           do_pop;
   logic                           do_push;

   // Next-state: shift on pop, then write the incoming entry behind the tail.
   always_comb begin
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      do_pop  = pop_i && (cnt_q != 2'd0);
      // Slot the new entry lands in once the pop (if any) has shifted.
      wr_slot = cnt_q - {1'b0, do_pop};
      do_push = push_i && (wr_slot < 2'd2);
      if (flush_i) begin
         cnt_d = 2'd0;
      end else begin
         if (do_pop) begin
            data_d[0] = data_q[1];
            err_d[0]  = err_q[1];
         end else begin
            data_d[0] = data_d[0];
         end
         if (do_push) begin
            case (wr_slot)
               2'd0: begin
                  data_d[0] = push_data_i;
                  err_d[0]  = push_err_i;
               end
               2'd1: begin
                  data_d[1] = push_data_i;
                  err_d[1]  = push_err_i;
               end
               default: begin
                  data_d[0] = data_d[0];
               end
            endcase
         end else begin
            data_d[0] = data_d[0];
         end
         cnt_d = cnt_q - {1'b0, do_pop} + {1'b0, do_push};
      end
   end

   // Occupancy counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are only meaningful below cnt_q, so no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      err_q  <= err_d;
   end

   assign cnt_o       = cnt_q;
   assign head_data_o = data_q[0];
   assign head_err_o  = err_q[0];

endmodule : inst_rsp_fifo

// File: rtl/inst_mem_sync.sv
// -----------------------------------------------------------------------------
// inst_mem_sync
// Synchronous instruction memory between the fetch stage and on-chip SRAM.
// Requests are accepted with a valid/ready handshake, read with one cycle of
// latency (stage s1) and returned through a fall-through 2-entry buffer that
// absorbs consumer back-pressure. A loader port writes bytes into the array.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid_i    fetch request valid
//   req_ready_o    request accepted when high together with req_valid_i
//   req_addr_i     fetch byte address
//   rsp_valid_o    response valid
//   rsp_ready_i    consumer takes the response
//   rsp_inst_o     instruction word (zero when errored or idle)
//   rsp_err_o      request was misaligned or out of range
//   flush_i        drop all outstanding requests/responses (branch redirect)
//   wr_en_i        loader write strobe (blocks fetch acceptance this cycle)
//   wr_addr_i      loader byte address
//   wr_data_i      loader data
//   wr_be_i        loader byte enables
//   wr_ack_o       one-cycle pulse after each write strobe
// -----------------------------------------------------------------------------
module inst_mem_sync
   import inst_mem_sync_pkg::*;
#(
   parameter int    DATA_W     = INST_W,
   parameter int    ADDR_W     = INST_ADDR_W,
   parameter int    DEPTH_LOG2 = INST_MEM_DEPTH_LOG2,
   parameter string INIT_FILE  = ""
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [ADDR_W-1:0]   req_addr_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_inst_o,
   output logic                rsp_err_o,
   input  logic                flush_i,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic [DATA_W/8-1:0] wr_be_i,
   output logic                wr_ack_o
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam int                BE_W      = DATA_W / 8;
   localparam int                HI_W      = ADDR_W - DEPTH_LOG2 - 2;
   localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

   // Misaligned or beyond the array: such accesses never touch the RAM.
   function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
      return (addr[1:0] != 2'b00) ||
             (addr[ADDR_W-1:DEPTH_LOG2+2] != {HI_W{1'b0}});
   endfunction

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic                  s1_valid_q;
   logic                  s1_err_q;
   logic [DATA_W-1:0]     s1_data_q;
   logic                  wr_ack_q;

   logic [DEPTH_LOG2-1:0] rd_idx;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic                  req_err;
   logic                  wr_err;
   logic                  accept;
   logic [1:0]            occupancy;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [1:0]            fifo_cnt;
   logic [DATA_W-1:0]     fifo_head_data;
   logic                  fifo_head_err;

   assign rd_idx     = req_addr_i[DEPTH_LOG2+1:2];
   assign wr_idx     = wr_addr_i[DEPTH_LOG2+1:2];
   assign req_err    = addr_err(req_addr_i);
   assign wr_err     = addr_err(wr_addr_i);
   assign occupancy  = fifo_cnt + {1'b0, s1_valid_q};
   assign fifo_empty = (fifo_cnt == 2'd0);

   // Acceptance: the loader has priority; a flush frees every slot for the
   // redirect target. Depends only on registered occupancy, never on
   // rsp_ready_i, which keeps the buffer bounded at two entries.
   always_comb begin
      req_ready_o = 1'b0;
      if (wr_en_i) begin
         req_ready_o = 1'b0;
      end else if (flush_i) begin
         req_ready_o = 1'b1;
      end else begin
         req_ready_o = (occupancy < 2'd2);
      end
   end

   assign accept = req_valid_i && req_ready_o;

   // Response selection: buffer head first, else s1 falls straight through.
   always_comb begin
      rsp_valid_o = 1'b0;
      rsp_inst_o  = ZERO_DATA;
      rsp_err_o   = 1'b0;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      if (flush_i) begin
         rsp_valid_o = 1'b0;
      end else if (!fifo_empty) begin
         rsp_valid_o = 1'b1;
         rsp_inst_o  = fifo_head_data;
         rsp_err_o   = fifo_head_err;
         fifo_pop    = rsp_ready_i;
         // The buffer is non-empty, so s1 can only queue behind it.
         fifo_push   = s1_valid_q;
      end else if (s1_valid_q) begin
         rsp_valid_o = 1'b1;
         rsp_inst_o  = s1_data_q;
         rsp_err_o   = s1_err_q;
         fifo_push   = !rsp_ready_i;
      end else begin
         rsp_valid_o = 1'b0;
      end
   end

   // s1 stage: every s1 entry is either consumed, buffered or flushed at the
   // edge, so validity next cycle is simply whether a request is accepted now.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         s1_err_q   <= accept ? req_err : s1_err_q;
      end
   end

   // Synchronous RAM read into s1; errored requests carry a zero word.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_data_q <= req_err ? ZERO_DATA : mem_q[rd_idx];
      end else begin
         s1_data_q <= s1_data_q;
      end
   end

   // Byte-enabled loader write; invalid addresses are dropped silently.
   always_ff @(posedge clk) begin
      if (wr_en_i && !wr_err) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be_i[b]) begin
               mem_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
         end
      end
   end

   // Write acknowledge, one cycle after every strobe (dropped writes too).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ack_q <= 1'b0;
      end else begin
         wr_ack_q <= wr_en_i;
      end
   end

   assign wr_ack_o = wr_ack_q;

   inst_rsp_fifo #(
      .DATA_W (DATA_W)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .push_i      (fifo_push),
      .pop_i       (fifo_pop),
      .push_data_i (s1_data_q),
      .push_err_i  (s1_err_q),
      .cnt_o       (fifo_cnt),
      .head_data_o (fifo_head_data),
      .head_err_o  (fifo_head_err)
   );

endmodule : inst_mem_sync

// File: tb/tb_inst_mem_sync.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_sync
// Directed bench for inst_mem_sync. A reference model (word array plus an
// in-order queue of outstanding responses) is checked against the DUT on
// every falling edge; directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_inst_mem_sync;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic        rsp_err;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic        wr_ack;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   // Reference model state.
   logic [31:0] mem_m [4096];
   logic [32:0] rsp_q [$];   // {err, word} in issue order
   logic        exp_ack = 1'b0;

   inst_mem_sync dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_inst_o  (rsp_inst),
      .rsp_err_o   (rsp_err),
      .flush_i     (flush),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .wr_be_i     (wr_be),
      .wr_ack_o    (wr_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:14] != 18'd0);
   endfunction

   // Model compare and update, once per cycle with inputs stable.
   always @(negedge clk) begin
      if (mon_en) begin
         logic        exp_rdy;
         logic        exp_v;
         logic [32:0] e;
         exp_rdy = !wr_en && (flush || rsp_q.size() < 2);
         exp_v   = (rsp_q.size() != 0) && !flush;
         chk("m_req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
         chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
         if (exp_v) begin
            chk("m_rsp_inst", rsp_inst, rsp_q[0][31:0]);
            chk("m_rsp_err", {31'd0, rsp_err}, {31'd0, rsp_q[0][32]});
         end else begin
            chk("m_idle_inst", rsp_inst, 32'h0000_0000);
         end
         chk("m_wr_ack", {31'd0, wr_ack}, {31'd0, exp_ack});
         if (rst) begin
            rsp_q.delete();
            exp_ack = 1'b0;
         end else begin
            exp_ack = wr_en;
            if (wr_en && !bad_addr(wr_addr)) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_be[b]) mem_m[wr_addr[13:2]][8*b +: 8] = wr_data[8*b +: 8];
               end
            end
            if (flush) rsp_q.delete();
            else if (exp_v && rsp_ready) void'(rsp_q.pop_front());
            if (req_valid && exp_rdy) begin
               e[32]   = bad_addr(req_addr);
               e[31:0] = e[32] ? 32'h0000_0000 : mem_m[req_addr[13:2]];
               rsp_q.push_back(e);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem_m[i] = 32'h0000_0000;
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b1;
      flush = 1'b0; wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_be = 4'h0;
      nxt(); nxt();
      rst = 1'b0;
      mon_en = 1'b1;
      smp();
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_ack", {31'd0, wr_ack}, 32'd0);
      chk("rst_inst", rsp_inst, 32'h0000_0000);
      nxt();

      // 1. Load words 0..7, then stream reads back-to-back.
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = i * 4; wr_data = 32'h1111_1111 * (i + 1); wr_be = 4'hF;
         smp();
         if (i == 0) chk("ld_ready_low", {31'd0, req_ready}, 32'd0);
         if (i == 1) chk("ld_ack", {31'd0, wr_ack}, 32'd1);
         nxt();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_addr = i * 4;
         smp();
         chk("st_ready", {31'd0, req_ready}, 32'd1);
         if (i > 0) begin
            chk("st_valid", {31'd0, rsp_valid}, 32'd1);
            chk("st_inst", rsp_inst, 32'h1111_1111 * i);
         end
         nxt();
      end
      req_valid = 1'b0;
      smp(); chk("st_last", rsp_inst, 32'h8888_8888); nxt();
      smp(); chk("st_drain", {31'd0, rsp_valid}, 32'd0); nxt();

      // 2. Back-pressure: consumer stalls 4 cycles.
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
      smp(); chk("bp_a_ready", {31'd0, req_ready}, 32'd1); nxt();
      req_addr = 32'h4;
      smp(); chk("bp_b_inst", rsp_inst, 32'h1111_1111); nxt();
      req_addr = 32'h8;
      smp(); chk("bp_c_ready", {31'd0, req_ready}, 32'd0); nxt();
      smp(); chk("bp_d_ready", {31'd0, req_ready}, 32'd0); nxt();
      rsp_ready = 1'b1;
      smp(); chk("bp_e_inst", rsp_inst, 32'h1111_1111);
             chk("bp_e_ready", {31'd0, req_ready}, 32'd0); nxt();
      smp(); chk("bp_f_inst", rsp_inst, 32'h2222_2222);
             chk("bp_f_ready", {31'd0, req_ready}, 32'd1); nxt();
      req_valid = 1'b0;
      smp(); chk("bp_g_inst", rsp_inst, 32'h3333_3333); nxt();
      smp(); chk("bp_h_valid", {31'd0, rsp_valid}, 32'd0); nxt();

      // 3. Misaligned and out-of-range requests.
      req_valid = 1'b1; req_addr = 32'h2;
      smp(); nxt();
      req_addr = 32'h4000;
      smp(); chk("er_a_err", {31'd0, rsp_err}, 32'd1); chk("er_a_inst", rsp_inst, 32'h0); nxt();
      req_addr = 32'h4;
      smp(); chk("er_b_err", {31'd0, rsp_err}, 32'd1); chk("er_b_inst", rsp_inst, 32'h0); nxt();
      req_valid = 1'b0;
      smp(); chk("er_c_err", {31'd0, rsp_err}, 32'd0); chk("er_c_inst", rsp_inst, 32'h2222_2222); nxt();

      // 4. Flush with two responses buffered and a redirect request.
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
      smp(); nxt();
      req_addr = 32'h4;
      smp(); nxt();
      req_valid = 1'b0;
      smp(); chk("fl_buf_inst", rsp_inst, 32'h1111_1111); nxt();
      flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
      smp(); chk("fl_ready", {31'd0, req_ready}, 32'd1); chk("fl_valid", {31'd0, rsp_valid}, 32'd0); nxt();
      flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      smp(); chk("fl_tgt_valid", {31'd0, rsp_valid}, 32'd1); chk("fl_tgt_inst", rsp_inst, 32'h5555_5555); nxt();
      smp(); chk("fl_empty", {31'd0, rsp_valid}, 32'd0); nxt();

      // 5. Byte-enabled writes, read-after-write, dropped out-of-range write.
      wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hAABB_CCDD; wr_be = 4'hF;
      req_valid = 1'b1; req_addr = 32'h0;
      smp(); chk("wr_a_ready", {31'd0, req_ready}, 32'd0); nxt();
      wr_be = 4'b0010; wr_data = 32'h0000_1100; req_valid = 1'b0;
      smp(); chk("wr_b_ready", {31'd0, req_ready}, 32'd0); chk("wr_b_ack", {31'd0, wr_ack}, 32'd1); nxt();
      wr_en = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
      smp(); chk("wr_c_ack", {31'd0, wr_ack}, 32'd1); nxt();
      req_valid = 1'b0;
      smp(); chk("wr_d_inst", rsp_inst, 32'hAABB_11DD); chk("wr_d_ack", {31'd0, wr_ack}, 32'd0); nxt();
      wr_en = 1'b1; wr_addr = 32'h4008; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
      smp(); nxt();
      wr_en = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
      smp(); chk("wr_oor_ack", {31'd0, wr_ack}, 32'd1); nxt();
      req_valid = 1'b0;
      smp(); chk("wr_oor_inst", rsp_inst, 32'hAABB_11DD); nxt();

      // 6. Reset with s1 and the buffer occupied and a write just acked.
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
      smp(); nxt();
      req_addr = 32'h4;
      smp(); nxt();
      req_valid = 1'b0; wr_en = 1'b1; wr_addr = 32'h1C; wr_data = 32'h8888_8888; wr_be = 4'hF;
      smp(); nxt();
      wr_en = 1'b0; rst = 1'b1;
      smp(); chk("rs_pre_ack", {31'd0, wr_ack}, 32'd1); nxt();
      rst = 1'b0; rsp_ready = 1'b1;
      smp();
      chk("rs_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rs_ready", {31'd0, req_ready}, 32'd1);
      chk("rs_ack", {31'd0, wr_ack}, 32'd0);
      nxt();
      req_valid = 1'b1; req_addr = 32'h1C;
      smp(); nxt();
      req_valid = 1'b0;
      smp(); chk("rs_mem_inst", rsp_inst, 32'h8888_8888); nxt();
      smp(); nxt();

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_inst_mem_sync
